bht_assoc: RTL and testbench
============================

# bht_assoc

Set-associative branch history / target buffer for the 5-stage pipeline. It is the parametrised successor of the direct-mapped BHT and generalises depth, associativity and counter width. It predicts direction and target in IF from a combinational table read, then trains in EX with saturating counters, tagged allocation and per-set round-robin replacement. It also produces the EX-stage mispredict flag, the corrected fetch address and two performance counters.

## Interface
- INDEX_LEN, 4, set index bits; SETS = 2^INDEX_LEN, index = PC[INDEX_LEN+1:2]
- WAYS, 2, ways per set; power of two, 1..8
- CNT_W, 2, saturating counter width, ≥2; predict taken when MSB=1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- PCF  in  32  fetch PC
- PredF  out  1  predicted taken
- NPC_PredF  out  32  predicted next PC
- HitF  out  1  PCF tag hit in any valid way
- PCE  in  32  PC of instruction in EX
- IsBranchE  in  1  EX holds a resolved conditional branch (training strobe)
- BranchE  in  1  actual direction (1 = taken)
- PredE  in  1  PredF carried down the pipe for this instruction
- NPC_PredE  in  32  NPC_PredF carried down the pipe
- BrNPC  in  32  actual taken target
- MispredE  out  1  redirect required
- NPC_FixE  out  32  corrected fetch address
- StatBrCnt  out  32  resolved branches, saturating
- StatMissCnt  out  32  mispredictions, saturating

## Operation
- Tag = PC[31:INDEX_LEN+2], (30−INDEX_LEN) bits.
- Per-entry state: valid, tag, target[31:0], counter[CNT_W-1:0].
- Per-set state: victim pointer, log2(WAYS) bits (absent when WAYS=1).

**Prediction (combinational on PCF)**
- A hit is a valid way with a matching tag.
- If more than one way hits, the lowest-numbered way is used.
- PredF = hit & counter MSB.
- NPC_PredF = target when PredF=1, else PCF+4 (32-bit wrap).

**Training (on edge when IsBranchE=1)**, in the set selected by PCE:
- Hit, taken: counter increments, saturating at all-ones; target ← BrNPC.
- Hit, not taken: counter decrements, saturating at 0; target unchanged.
- Miss, taken: allocate into the way at the victim pointer.
  - valid ← 1, tag ← PCE tag, target ← BrNPC, counter ← weakly taken (MSB=1, rest 0).
  - Victim pointer increments modulo WAYS.
- Miss, not taken: no change to the table.
- A hit does not move the victim pointer.

**Mispredict (combinational, EX)**
- MispredE = IsBranchE & ((PredE≠BranchE) | (PredE & BranchE & NPC_PredE≠BrNPC)).
- NPC_FixE = BranchE ? BrNPC : PCE+4. The value is valid regardless of MispredE.

**Statistics**
- StatBrCnt increments on every IsBranchE.
- StatMissCnt increments on every MispredE.
- Both saturate at 0xFFFF_FFFF.

## Timing
- Prediction latency 0: the outputs follow PCF within the same cycle.
- Training takes effect at the next rising edge. A PCF read in the same cycle as an update to the same entry returns the pre-update value.
- Reset (asynchronous, active-low): clears all valid bits, counters to 0, victim pointers to 0, stat counters to 0.
  - During and after reset: PredF=0, HitF=0, NPC_PredF=PCF+4.
  - MispredE and NPC_FixE stay combinational from their inputs; MispredE=0 whenever IsBranchE=0.
- Reset asserted mid-update: the update is lost, and every table entry reads invalid once reset is released.
- IsBranchE=0: no state changes, including the stat counters.
- PC aliasing: different tags sharing a set index coexist up to WAYS entries; the (WAYS+1)th distinct taken branch evicts in round-robin order.

## Test plan
- Reset, then PCF=0x100 → PredF=0, HitF=0, NPC_PredF=0x104; all stats 0.
- Train PCE=0x100, BranchE=1, BrNPC=0x200, PredE=0 → next cycle PCF=0x100 gives HitF=1, PredF=1, NPC_PredF=0x200; this cycle MispredE=1, NPC_FixE=0x200, StatMissCnt=1.
- Same entry, CNT_W=2: two not-taken updates → counter 00, PredF=0, NPC_PredF=0x104. Three taken updates → counter 11. A further taken update keeps it at 11.
- INDEX_LEN=4, WAYS=2: taken branches at 0x100, 0x140, 0x180 (same set 0) → 0x100 evicted (HitF=0), 0x140 and 0x180 hit.
- PredE=1, BranchE=1, NPC_PredE=0x200, BrNPC=0x300 → MispredE=1, NPC_FixE=0x300, target updated to 0x300.
- Same-cycle update and read at PCF=PCE=0x100 on a fresh entry → PredF=0 that cycle, PredF=1 the next. Assert rst low mid-stream → all entries invalid and stats 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bht_assoc.sv
// Set-associative branch history / target buffer.
//
// Predicts direction and target in IF from a combinational lookup on PCF, trains in EX with
// saturating counters, tagged allocation and per-set round-robin replacement, and produces the
// EX-stage mispredict flag, the corrected fetch address and two saturating statistics counters.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   PCF               fetch PC
//   PredF, NPC_PredF  predicted direction / predicted next PC
//   HitF              PCF tag hit in any valid way
//   PCE               PC of the instruction in EX
//   IsBranchE         resolved conditional branch in EX (training strobe)
//   BranchE, BrNPC    actual direction / actual taken target
//   PredE, NPC_PredE  prediction carried down the pipe for this instruction
//   MispredE          redirect required
//   NPC_FixE          corrected fetch address
//   StatBrCnt         resolved branches (saturating)
//   StatMissCnt       mispredictions (saturating)
module bht_assoc #(
   parameter int unsigned INDEX_LEN = 4,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned CNT_W     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   output logic        PredF,
   output logic [31:0] NPC_PredF,
   output logic        HitF,
   input  logic [31:0] PCE,
   input  logic        IsBranchE,
   input  logic        BranchE,
   input  logic        PredE,
   input  logic [31:0] NPC_PredE,
   input  logic [31:0] BrNPC,
   output logic        MispredE,
   output logic [31:0] NPC_FixE,
   output logic [31:0] StatBrCnt,
   output logic [31:0] StatMissCnt
);

   localparam int unsigned SETS  = 1 << INDEX_LEN;
   localparam int unsigned TAG_W = 30 - INDEX_LEN;
   // Pointer kept one bit wide for WAYS=1 so the declarations stay legal; it never moves then.
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [WAY_W-1:0] WAY_ONE = {{(WAY_W-1){1'b0}}, 1'b1};

   logic                valid_q  [SETS][WAYS];
   logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
   logic [31:0]         target_q [SETS][WAYS];
   logic [CNT_W-1:0]    cnt_q    [SETS][WAYS];
   logic [WAY_W-1:0]    victim_q [SETS];
   logic [31:0]         br_cnt_q;
   logic [31:0]         miss_cnt_q;

   logic [INDEX_LEN-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]     tag_f, tag_e;
   logic                 hit_f, hit_e;
   logic [WAY_W-1:0]     way_f, way_e;
   logic [CNT_W-1:0]     cnt_e;

   // Word-alignment bits never take part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

   assign idx_f = PCF[INDEX_LEN+1:2];
   assign tag_f = PCF[31:INDEX_LEN+2];
   assign idx_e = PCE[INDEX_LEN+1:2];
   assign tag_e = PCE[31:INDEX_LEN+2];

   // Lookup, scanning from the top way down so the lowest-numbered hitting way wins.
   always_comb begin
      hit_f = 1'b0;
      way_f = '0;
      hit_e = 1'b0;
      way_e = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx_f][w] && (tag_q[idx_f][w] == tag_f)) begin
            hit_f = 1'b1;
            way_f = WAY_W'(w);
         end
         if (valid_q[idx_e][w] && (tag_q[idx_e][w] == tag_e)) begin
            hit_e = 1'b1;
            way_e = WAY_W'(w);
         end
      end
   end

   assign cnt_e = cnt_q[idx_e][way_e];

   // Prediction outputs; an invalid table after reset naturally yields fall-through.
   always_comb begin
      PredF     = hit_f & cnt_q[idx_f][way_f][CNT_W-1];
      HitF      = hit_f;
      NPC_PredF = PredF ? target_q[idx_f][way_f] : PCF + 32'd4;
   end

   // Mispredict and redirect address.
   always_comb begin
      MispredE = IsBranchE & ((PredE != BranchE) |
                              (PredE & BranchE & (NPC_PredE != BrNPC)));
      NPC_FixE = BranchE ? BrNPC : PCE + 32'd4;
   end

   // Table training.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            victim_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               cnt_q[s][w]    <= '0;
            end
         end
      end else if (IsBranchE) begin
         if (hit_e) begin
            if (BranchE) begin
               target_q[idx_e][way_e] <= BrNPC;
               if (cnt_e != CNT_MAX) cnt_q[idx_e][way_e] <= cnt_e + CNT_ONE;
            end else if (cnt_e != CNT_MIN) begin
               cnt_q[idx_e][way_e] <= cnt_e - CNT_ONE;
            end
         end else if (BranchE) begin
            valid_q[idx_e][victim_q[idx_e]]  <= 1'b1;
            tag_q[idx_e][victim_q[idx_e]]    <= tag_e;
            target_q[idx_e][victim_q[idx_e]] <= BrNPC;
            cnt_q[idx_e][victim_q[idx_e]]    <= CNT_WT;
            // WAYS is a power of two, so the natural wrap of the pointer is modulo WAYS.
            if (WAYS > 1) victim_q[idx_e] <= victim_q[idx_e] + WAY_ONE;
         end
      end
   end

   // Saturating statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (IsBranchE && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
         if (MispredE && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign StatBrCnt   = br_cnt_q;
   assign StatMissCnt = miss_cnt_q;

endmodule

// File: tb/tb_bht_assoc.sv
module tb_bht_assoc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] PCF = '0;
   logic        PredF;
   logic [31:0] NPC_PredF;
   logic        HitF;
   logic [31:0] PCE = '0;
   logic        IsBranchE = 1'b0;
   logic        BranchE = 1'b0;
   logic        PredE = 1'b0;
   logic [31:0] NPC_PredE = '0;
   logic [31:0] BrNPC = '0;
   logic        MispredE;
   logic [31:0] NPC_FixE;
   logic [31:0] StatBrCnt;
   logic [31:0] StatMissCnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bht_assoc #(.INDEX_LEN(4), .WAYS(2), .CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCF        (PCF),
      .PredF      (PredF),
      .NPC_PredF  (NPC_PredF),
      .HitF       (HitF),
      .PCE        (PCE),
      .IsBranchE  (IsBranchE),
      .BranchE    (BranchE),
      .PredE      (PredE),
      .NPC_PredE  (NPC_PredE),
      .BrNPC      (BrNPC),
      .MispredE   (MispredE),
      .NPC_FixE   (NPC_FixE),
      .StatBrCnt  (StatBrCnt),
      .StatMissCnt(StatMissCnt)
   );

   typedef struct {
      logic        isb;
      logic [31:0] pce;
      logic        br;
      logic [31:0] brnpc;
      logic        prede;
      logic [31:0] npc_prede;
      logic [31:0] pcf;       // fetch PC probed after the edge
      logic        e_mis;     // expected MispredE before the edge
      logic [31:0] e_fix;     // expected NPC_FixE before the edge
      logic        e_hit;     // expected lookup on pcf after the edge
      logic        e_pred;
      logic [31:0] e_npc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic isb, logic [31:0] pce, logic br, logic [31:0] brnpc,
                               logic prede, logic [31:0] npc_prede, logic [31:0] pcf,
                               logic e_mis, logic [31:0] e_fix,
                               logic e_hit, logic e_pred, logic [31:0] e_npc);
      vec_t v;
      v.isb = isb; v.pce = pce; v.br = br; v.brnpc = brnpc; v.prede = prede;
      v.npc_prede = npc_prede; v.pcf = pcf; v.e_mis = e_mis; v.e_fix = e_fix;
      v.e_hit = e_hit; v.e_pred = e_pred; v.e_npc = e_npc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic probe(string name, logic e_hit, logic e_pred, logic [31:0] e_npc);
      chk({name, " HitF"}, {31'd0, HitF}, {31'd0, e_hit});
      chk({name, " PredF"}, {31'd0, PredF}, {31'd0, e_pred});
      chk({name, " NPC_PredF"}, NPC_PredF, e_npc);
   endtask

   initial begin
      // counter 2'b10 after v1, walks down to 00, up to 11, saturates, etc.
      vecs.push_back(mk(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100, 1, 32'h200, 1, 1, 32'h200));
      vecs.push_back(mk(1, 32'h100, 0, 32'h200, 1, 32'h200, 32'h100, 1, 32'h104, 1, 0, 32'h104));
      vecs.push_back(mk(1, 32'h100, 0, 32'h200, 0, 32'h104, 32'h100, 0, 32'h104, 1, 0, 32'h104));
      vecs.push_back(mk(1, 32'h100, 0, 32'h200, 0, 32'h104, 32'h100, 0, 32'h104, 1, 0, 32'h104));
      vecs.push_back(mk(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100, 1, 32'h200, 1, 0, 32'h104));
      vecs.push_back(mk(1, 32'h100, 1, 32'h200, 0, 32'h104, 32'h100, 1, 32'h200, 1, 1, 32'h200));
      vecs.push_back(mk(1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100, 0, 32'h200, 1, 1, 32'h200));
      vecs.push_back(mk(1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100, 0, 32'h200, 1, 1, 32'h200));
      // saturated at 11: one not-taken leaves 10, still predicting taken
      vecs.push_back(mk(1, 32'h100, 0, 32'h200, 1, 32'h200, 32'h100, 1, 32'h104, 1, 1, 32'h200));
      // right direction, wrong target
      vecs.push_back(mk(1, 32'h100, 1, 32'h300, 1, 32'h200, 32'h100, 1, 32'h300, 1, 1, 32'h300));
      // not-taken miss: no allocation
      vecs.push_back(mk(1, 32'h500, 0, 32'h0, 0, 32'h504, 32'h500, 0, 32'h504, 0, 0, 32'h504));
      // set 0 aliasing: 0x140 into way 1, 0x180 evicts 0x100 from way 0
      vecs.push_back(mk(1, 32'h140, 1, 32'h240, 0, 32'h144, 32'h140, 1, 32'h240, 1, 1, 32'h240));
      vecs.push_back(mk(1, 32'h180, 1, 32'h280, 0, 32'h184, 32'h180, 1, 32'h280, 1, 1, 32'h280));
      // no training strobe: MispredE held low despite PredE != BranchE
      vecs.push_back(mk(0, 32'h100, 0, 32'h0, 1, 32'h200, 32'h100, 0, 32'h104, 0, 0, 32'h104));
      vecs.push_back(mk(0, 32'h100, 0, 32'h0, 0, 32'h0, 32'h140, 0, 32'h104, 1, 1, 32'h240));
      // hit on 0x180 must not move the victim pointer (still way 1)
      vecs.push_back(mk(1, 32'h180, 1, 32'h280, 1, 32'h280, 32'h180, 0, 32'h280, 1, 1, 32'h280));
      vecs.push_back(mk(1, 32'h1C0, 1, 32'h2C0, 0, 32'h1C4, 32'h1C0, 1, 32'h2C0, 1, 1, 32'h2C0));
      vecs.push_back(mk(0, 32'h100, 0, 32'h0, 0, 32'h0, 32'h180, 0, 32'h104, 1, 1, 32'h280));
      vecs.push_back(mk(0, 32'h100, 0, 32'h0, 0, 32'h0, 32'h140, 0, 32'h104, 0, 0, 32'h144));
      // 32-bit wrap of PC+4 on both paths
      vecs.push_back(mk(0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0));

      // Reset state
      PCF = 32'h100;
      #12;
      probe("reset", 0, 0, 32'h104);
      chk("reset StatBrCnt", StatBrCnt, 32'd0);
      chk("reset StatMissCnt", StatMissCnt, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #2;

      foreach (vecs[i]) begin
         IsBranchE = vecs[i].isb;
         PCE       = vecs[i].pce;
         BranchE   = vecs[i].br;
         BrNPC     = vecs[i].brnpc;
         PredE     = vecs[i].prede;
         NPC_PredE = vecs[i].npc_prede;
         PCF       = vecs[i].pcf;
         #1;
         chk($sformatf("v%0d MispredE", i), {31'd0, MispredE}, {31'd0, vecs[i].e_mis});
         chk($sformatf("v%0d NPC_FixE", i), NPC_FixE, vecs[i].e_fix);
         @(posedge clk);
         #1;
         IsBranchE = 1'b0;
         #1;
         probe($sformatf("v%0d", i), vecs[i].e_hit, vecs[i].e_pred, vecs[i].e_npc);
      end
      chk("table StatBrCnt", StatBrCnt, 32'd15);
      chk("table StatMissCnt", StatMissCnt, 32'd9);

      // Same-cycle update and read on a fresh entry returns the pre-update value
      IsBranchE = 1'b1; PCE = 32'h304; BranchE = 1'b1; BrNPC = 32'h400;
      PredE = 1'b0; NPC_PredE = 32'h308; PCF = 32'h304;
      #1;
      probe("same-cycle before", 0, 0, 32'h308);
      @(posedge clk);
      #1;
      IsBranchE = 1'b0;
      #1;
      probe("same-cycle after", 1, 1, 32'h400);
      chk("pre-reset StatBrCnt", StatBrCnt, 32'd16);
      chk("pre-reset StatMissCnt", StatMissCnt, 32'd10);

      // Asynchronous reset in the middle of a training cycle
      IsBranchE = 1'b1; PCE = 32'h308; BranchE = 1'b1; BrNPC = 32'h500;
      PredE = 1'b0; NPC_PredE = 32'h30C; PCF = 32'h304;
      #2;
      rst = 1'b0;
      #1;
      probe("async reset", 0, 0, 32'h308);
      chk("async reset StatBrCnt", StatBrCnt, 32'd0);
      chk("async reset StatMissCnt", StatMissCnt, 32'd0);
      chk("reset MispredE comb", {31'd0, MispredE}, 32'd1);
      chk("reset NPC_FixE comb", NPC_FixE, 32'h500);
      @(posedge clk);
      #2;
      IsBranchE = 1'b0;
      rst = 1'b1;
      #1;
      PCF = 32'h308;
      #1;
      probe("lost update", 0, 0, 32'h30C);
      PCF = 32'h180;
      #1;
      probe("post reset 0x180", 0, 0, 32'h184);
      @(posedge clk);
      #2;
      chk("post reset StatBrCnt", StatBrCnt, 32'd0);
      chk("post reset StatMissCnt", StatMissCnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
